// File: rtl/mem_access_stage_pkg.sv
// Shared widths and state encoding for the memory-access pipeline stage.
package mem_access_stage_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int REG_NUM_WIDTH   = 5;
  localparam int DMEM_ADDR_WIDTH = 10;

  typedef enum logic {
    MEM_ST_IDLE = 1'b0,
    MEM_ST_WAIT = 1'b1
  } mem_state_e;

  function automatic logic is_memop(input logic is_load, input logic is_store);
    return is_load | is_store;
  endfunction

endpackage

// File: rtl/mem_access_stage_timeout_counter.sv
// WAIT-cycle counter for the memory stage; o_limit_hit flags the last cycle before abort.
module mem_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_limit_hit
);

  localparam int CW = $clog2(LIMIT) + 1;

  logic [CW-1:0] r_count;
  logic          w_limit_hit;

  assign w_limit_hit = (r_count == CW'(LIMIT - 1));
  assign o_limit_hit = w_limit_hit;

  // Saturate at the limit; the owner leaves WAIT on that edge anyway.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_limit_hit) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM consumer: runs the data-memory access and registers the MEM/WB payload.
// Optional abort on a stuck access is enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = mem_access_stage_pkg::DMEM_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      ALUOutIn,
  input  logic [DATA_WIDTH-1:0]      RdDataBIn,
  input  logic                       IsLoadInsnIn,
  input  logic                       IsStoreInsnIn,
  input  logic                       RfWrEnableIn,
  input  logic [REG_NUM_WIDTH-1:0]   WrNumIn,
  output logic                       StallOut,
  output logic                       DmemReq,
  output logic                       DmemWe,
  output logic [DMEM_ADDR_WIDTH-1:0] DmemAddr,
  output logic [DATA_WIDTH-1:0]      DmemWrData,
  input  logic [DATA_WIDTH-1:0]      DmemRdData,
  input  logic                       DmemAck,
  output logic [DATA_WIDTH-1:0]      WbDataOut,
  output logic [REG_NUM_WIDTH-1:0]   WrNumOut,
  output logic                       RfWrEnableOut,
  output logic                       MemErrOut,
  output logic                       o_dbg_state
);

  // Memory handshake: DmemReq rises with address/data/we and all four hold
  // steady until the cycle DmemAck is sampled high; that edge drops DmemReq.
  // DmemRdData is only meaningful in the ack cycle. Ack while idle is ignored.

  mem_state_e                 r_state;
  logic                       r_dmem_req;
  logic                       r_dmem_we;
  logic [DMEM_ADDR_WIDTH-1:0] r_dmem_addr;
  logic [DATA_WIDTH-1:0]      r_dmem_wr_data;
  logic [DATA_WIDTH-1:0]      r_wb_data;
  logic [REG_NUM_WIDTH-1:0]   r_wr_num;
  logic                       r_rf_wr_en;
  logic                       r_mem_err;

  logic w_memop;
  logic w_idle;
  logic w_wait;
  logic w_limit_hit;

  assign w_memop = is_memop(IsLoadInsnIn, IsStoreInsnIn);
  assign w_idle  = (r_state == MEM_ST_IDLE);
  assign w_wait  = (r_state == MEM_ST_WAIT);

`ifdef MEM_TIMEOUT_EN
  mem_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_clear    (w_idle & w_memop),
    .i_enable   (w_wait & ~DmemAck),
    .o_limit_hit(w_limit_hit)
  );
`else
  assign w_limit_hit = 1'b0;
  // Without the timeout the limit only has to be a sane value.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_limit
  end
`endif

  // Gated by reset so an in-flight memop on the inputs cannot stall upstream while held in reset.
  assign StallOut = rst & ((w_idle & w_memop) | (w_wait & ~DmemAck & ~w_limit_hit));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= MEM_ST_IDLE;
      r_dmem_req     <= 1'b0;
      r_dmem_we      <= 1'b0;
      r_dmem_addr    <= '0;
      r_dmem_wr_data <= '0;
      r_wb_data      <= '0;
      r_wr_num       <= '0;
      r_rf_wr_en     <= 1'b0;
      r_mem_err      <= 1'b0;
    end else begin
      r_mem_err <= 1'b0;
      case (r_state)
        MEM_ST_IDLE: begin
          if (w_memop) begin
            r_state        <= MEM_ST_WAIT;
            r_dmem_req     <= 1'b1;
            r_dmem_we      <= IsStoreInsnIn & ~IsLoadInsnIn;
            r_dmem_addr    <= ALUOutIn[DMEM_ADDR_WIDTH+1:2];
            r_dmem_wr_data <= RdDataBIn;
            r_rf_wr_en     <= 1'b0;
          end else begin
            r_wb_data  <= ALUOutIn;
            r_wr_num   <= WrNumIn;
            r_rf_wr_en <= RfWrEnableIn;
          end
        end
        MEM_ST_WAIT: begin
          if (DmemAck) begin
            r_state    <= MEM_ST_IDLE;
            r_dmem_req <= 1'b0;
            r_wb_data  <= r_dmem_we ? ALUOutIn : DmemRdData;
            r_wr_num   <= WrNumIn;
            r_rf_wr_en <= RfWrEnableIn;
          end else if (w_limit_hit) begin
            r_state    <= MEM_ST_IDLE;
            r_dmem_req <= 1'b0;
            r_wb_data  <= '0;
            r_rf_wr_en <= 1'b0;
            r_mem_err  <= 1'b1;
          end else begin
            r_rf_wr_en <= 1'b0;
          end
        end
        default: r_state <= MEM_ST_IDLE;
      endcase
    end
  end

  assign DmemReq       = r_dmem_req;
  assign DmemWe        = r_dmem_we;
  assign DmemAddr      = r_dmem_addr;
  assign DmemWrData    = r_dmem_wr_data;
  assign WbDataOut     = r_wb_data;
  assign WrNumOut      = r_wr_num;
  assign RfWrEnableOut = r_rf_wr_en;
  assign MemErrOut     = r_mem_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: passthrough table plus memop/reset/timeout sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ALUOutIn = '0;
  logic [31:0] RdDataBIn = '0;
  logic        IsLoadInsnIn = 1'b0;
  logic        IsStoreInsnIn = 1'b0;
  logic        RfWrEnableIn = 1'b0;
  logic [4:0]  WrNumIn = '0;
  logic        StallOut;
  logic        DmemReq;
  logic        DmemWe;
  logic [9:0]  DmemAddr;
  logic [31:0] DmemWrData;
  logic [31:0] DmemRdData = '0;
  logic        DmemAck = 1'b0;
  logic [31:0] WbDataOut;
  logic [4:0]  WrNumOut;
  logic        RfWrEnableOut;
  logic        MemErrOut;
  logic        dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  mem_access_stage #(
    .DMEM_ADDR_WIDTH(10),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ALUOutIn     (ALUOutIn),
    .RdDataBIn    (RdDataBIn),
    .IsLoadInsnIn (IsLoadInsnIn),
    .IsStoreInsnIn(IsStoreInsnIn),
    .RfWrEnableIn (RfWrEnableIn),
    .WrNumIn      (WrNumIn),
    .StallOut     (StallOut),
    .DmemReq      (DmemReq),
    .DmemWe       (DmemWe),
    .DmemAddr     (DmemAddr),
    .DmemWrData   (DmemWrData),
    .DmemRdData   (DmemRdData),
    .DmemAck      (DmemAck),
    .WbDataOut    (WbDataOut),
    .WrNumOut     (WrNumOut),
    .RfWrEnableOut(RfWrEnableOut),
    .MemErrOut    (MemErrOut),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] rdb, input logic ld,
                       input logic st, input logic rfwe, input logic [4:0] wrnum);
    ALUOutIn      = alu;
    RdDataBIn     = rdb;
    IsLoadInsnIn  = ld;
    IsStoreInsnIn = st;
    RfWrEnableIn  = rfwe;
    WrNumIn       = wrnum;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One memop from the IDLE cycle through the ack edge; nack = WAIT cycles before ack.
  task automatic do_memop(input string nm, input logic [31:0] alu, input logic [31:0] rdb,
                          input logic ld, input logic st, input logic rfwe,
                          input logic [4:0] wrnum, input int nack, input logic [31:0] rddata,
                          input logic [9:0] exp_addr, input logic exp_we,
                          input logic [31:0] exp_wb);
    int stalls;
    stalls = 0;
    drive(alu, rdb, ld, st, rfwe, wrnum);
    DmemAck = 1'b0;
    @(negedge clk);
    stalls += int'(StallOut);
    tick();
    chk({nm, " req"}, 32'(DmemReq), 32'd1);
    chk({nm, " addr"}, 32'(DmemAddr), 32'(exp_addr));
    chk({nm, " we"}, 32'(DmemWe), 32'(exp_we));
    chk({nm, " wrdata"}, DmemWrData, rdb);
    chk({nm, " bubble"}, 32'(RfWrEnableOut), 32'd0);
    chk({nm, " state"}, 32'(dbg_state), 32'd1);
    for (int i = 0; i < nack; i++) begin
      @(negedge clk);
      stalls += int'(StallOut);
      tick();
      chk({nm, " req held"}, 32'(DmemReq), 32'd1);
      chk({nm, " addr held"}, 32'(DmemAddr), 32'(exp_addr));
      chk({nm, " wait rfwe"}, 32'(RfWrEnableOut), 32'd0);
    end
    DmemAck    = 1'b1;
    DmemRdData = rddata;
    @(negedge clk);
    chk({nm, " stall at ack"}, 32'(StallOut), 32'd0);
    tick();
    DmemAck    = 1'b0;
    DmemRdData = 32'h0;
    chk({nm, " req drop"}, 32'(DmemReq), 32'd0);
    chk({nm, " wbdata"}, WbDataOut, exp_wb);
    chk({nm, " wrnum"}, 32'(WrNumOut), 32'(wrnum));
    chk({nm, " rfwe"}, 32'(RfWrEnableOut), 32'(rfwe));
    chk({nm, " stall cycles"}, 32'(stalls), 32'(1 + nack));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] alu;
    logic [4:0]  wrnum;
    logic        rfwe;
    logic [31:0] exp_wb;
    logic [4:0]  exp_wrnum;
    logic        exp_rfwe;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{alu: 32'h0000_1234, wrnum: 5'd5,  rfwe: 1'b1, exp_wb: 32'h0000_1234, exp_wrnum: 5'd5,  exp_rfwe: 1'b1};
    vecs[1] = '{alu: 32'hFFFF_FFFF, wrnum: 5'd31, rfwe: 1'b0, exp_wb: 32'hFFFF_FFFF, exp_wrnum: 5'd31, exp_rfwe: 1'b0};
    vecs[2] = '{alu: 32'h0000_0000, wrnum: 5'd0,  rfwe: 1'b1, exp_wb: 32'h0000_0000, exp_wrnum: 5'd0,  exp_rfwe: 1'b1};
    vecs[3] = '{alu: 32'hCAFE_F00D, wrnum: 5'd17, rfwe: 1'b1, exp_wb: 32'hCAFE_F00D, exp_wrnum: 5'd17, exp_rfwe: 1'b1};

    // reset values
    tick();
    tick();
    chk("rst req", 32'(DmemReq), 32'd0);
    chk("rst we", 32'(DmemWe), 32'd0);
    chk("rst addr", 32'(DmemAddr), 32'd0);
    chk("rst wrdata", DmemWrData, 32'd0);
    chk("rst wb", WbDataOut, 32'd0);
    chk("rst wrnum", 32'(WrNumOut), 32'd0);
    chk("rst rfwe", 32'(RfWrEnableOut), 32'd0);
    chk("rst err", 32'(MemErrOut), 32'd0);
    chk("rst state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // non-memop passthrough table
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i].alu, 32'(i) * 32'h1111_0000, 1'b0, 1'b0, vecs[i].rfwe, vecs[i].wrnum);
      exp_q.push_back(vecs[i].exp_wb);
      @(negedge clk);
      chk("pass stall", 32'(StallOut), 32'd0);
      tick();
      chk("pass wb", WbDataOut, exp_q.pop_front());
      chk("pass wrnum", 32'(WrNumOut), 32'(vecs[i].exp_wrnum));
      chk("pass rfwe", 32'(RfWrEnableOut), 32'(vecs[i].exp_rfwe));
      chk("pass req", 32'(DmemReq), 32'd0);
    end

    // ack while idle must be ignored
    drive(32'h0000_0ABC, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7);
    DmemAck    = 1'b1;
    DmemRdData = 32'h1357_9BDF;
    tick();
    DmemAck = 1'b0;
    chk("idle ack req", 32'(DmemReq), 32'd0);
    chk("idle ack wb", WbDataOut, 32'h0000_0ABC);
    chk("idle ack state", 32'(dbg_state), 32'd0);

    // load at 0x40, three WAIT cycles without ack
    do_memop("load", 32'h0000_0040, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3, 3,
             32'hDEAD_BEEF, 10'h010, 1'b0, 32'hDEAD_BEEF);
    // store at 0x7, ack in first WAIT cycle; wb carries the ALU result
    do_memop("store", 32'h0000_0007, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b0, 5'd0, 0,
             32'h0, 10'h001, 1'b1, 32'h0000_0007);
    // back-to-back load then store
    do_memop("b2b load", 32'h0000_0204, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9, 0,
             32'h1111_2222, 10'h081, 1'b0, 32'h1111_2222);
    do_memop("b2b store", 32'h0000_03FC, 32'h55AA_55AA, 1'b0, 1'b1, 1'b0, 5'd2, 0,
             32'h0, 10'h0FF, 1'b1, 32'h0000_03FC);
    // both flags set is a load; high address bits dropped
    do_memop("both flags", 32'h0000_0FFC, 32'h7777_7777, 1'b1, 1'b1, 1'b1, 5'd12, 1,
             32'h0BAD_CAFE, 10'h3FF, 1'b0, 32'h0BAD_CAFE);
    do_memop("high addr", 32'hFFFF_F004, 32'h0, 1'b1, 1'b0, 1'b1, 5'd20, 0,
             32'h2468_ACE0, 10'h001, 1'b0, 32'h2468_ACE0);

    // reset asserted mid-WAIT
    drive(32'h0000_0080, 32'h0, 1'b1, 1'b0, 1'b1, 5'd4);
    tick();
    chk("midrst pre req", 32'(DmemReq), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst req", 32'(DmemReq), 32'd0);
    chk("midrst stall", 32'(StallOut), 32'd0);
    chk("midrst rfwe", 32'(RfWrEnableOut), 32'd0);
    chk("midrst state", 32'(dbg_state), 32'd0);
    drive(32'h0000_5A5A, 32'h0, 1'b0, 1'b0, 1'b1, 5'd6);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post rst wb", WbDataOut, 32'h0000_5A5A);
    chk("post rst wrnum", 32'(WrNumOut), 32'd6);
    chk("post rst rfwe", 32'(RfWrEnableOut), 32'd1);

`ifdef MEM_TIMEOUT_EN
    // no ack: abort after 4 WAIT cycles
    drive(32'h0000_0100, 32'h0, 1'b1, 1'b0, 1'b1, 5'd8);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("to stall", 32'(StallOut), 32'd1);
      chk("to err early", 32'(MemErrOut), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("to stall release", 32'(StallOut), 32'd0);
    tick();
    drive(32'h0000_0033, 32'h0, 1'b0, 1'b0, 1'b0, 5'd1);
    chk("to err pulse", 32'(MemErrOut), 32'd1);
    chk("to req", 32'(DmemReq), 32'd0);
    chk("to rfwe", 32'(RfWrEnableOut), 32'd0);
    chk("to wb", WbDataOut, 32'd0);
    chk("to state", 32'(dbg_state), 32'd0);
    tick();
    chk("to err clear", 32'(MemErrOut), 32'd0);
    // ack on the limit cycle completes normally
    do_memop("ack at limit", 32'h0000_0104, 32'h0, 1'b1, 1'b0, 1'b1, 5'd10, 3,
             32'h9999_0000, 10'h041, 1'b0, 32'h9999_0000);
    chk("ack at limit err", 32'(MemErrOut), 32'd0);
`else
    // long wait never aborts
    do_memop("long wait", 32'h0000_0100, 32'h0, 1'b1, 1'b0, 1'b1, 5'd8, 6,
             32'h3333_4444, 10'h040, 1'b0, 32'h3333_4444);
    chk("long wait err", 32'(MemErrOut), 32'd0);
`endif

    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer end of the EX/MEM pipeline register: takes the registered ALU result, store data, load/store flags and destination register, and executes the data-memory access.
- Drives a req/ack data-memory port and stalls upstream stages until the access completes.
- Produces the registered MEM/WB payload: write-back data, destination register number and register-file write enable.

Parameters:
- DMEM_ADDR_WIDTH, 10, word-address width of the data-memory port.
- TIMEOUT_CYCLES, 255, WAIT cycles before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- ALUOutIn  in  DATA_WIDTH  byte address for loads/stores, result otherwise.
- RdDataBIn  in  DATA_WIDTH  store data.
- IsLoadInsnIn  in  1  load present.
- IsStoreInsnIn  in  1  store present.
- RfWrEnableIn  in  1  register-file write request from EX.
- WrNumIn  in  REG_NUM_WIDTH  destination register.
- StallOut  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- DmemReq  out  1  access request.
- DmemWe  out  1  1 = store.
- DmemAddr  out  DMEM_ADDR_WIDTH  word address.
- DmemWrData  out  DATA_WIDTH  store data.
- DmemRdData  in  DATA_WIDTH  load data, valid with DmemAck.
- DmemAck  in  1  access complete.
- WbDataOut  out  DATA_WIDTH  MEM/WB data.
- WrNumOut  out  REG_NUM_WIDTH  MEM/WB destination register.
- RfWrEnableOut  out  1  MEM/WB write enable.
- MemErrOut  out  1  timeout pulse; tied 0 without MEM_TIMEOUT_EN.

Behaviour:
- Clock is clk. Reset rst is asynchronous, active-low.
- Reset: state IDLE. DmemReq, DmemWe, DmemAddr, DmemWrData, WbDataOut, WrNumOut, RfWrEnableOut and MemErrOut all 0.
- States:
  - IDLE (no access outstanding).
  - WAIT (request outstanding; DmemReq=1).
- Memop = IsLoadInsnIn | IsStoreInsnIn. If both flags are set, the access is a load (DmemWe=0).
- IDLE, no memop: MEM/WB registers load WbDataOut=ALUOutIn, WrNumOut=WrNumIn, RfWrEnableOut=RfWrEnableIn. Latency 1 cycle.
- IDLE, memop: at the next edge:
  - Go to WAIT.
  - Register DmemReq=1, DmemWe=IsStoreInsnIn & ~IsLoadInsnIn.
  - DmemAddr=ALUOutIn[DMEM_ADDR_WIDTH+1:2]; byte bits [1:0] are ignored (no misalignment trap).
  - DmemWrData=RdDataBIn.
  - MEM/WB gets a bubble: RfWrEnableOut=0.
- WAIT: DmemReq, DmemWe, DmemAddr and DmemWrData are held stable until ack. RfWrEnableOut=0 every cycle without ack.
- WAIT with DmemAck=1: at that edge:
  - DmemReq=0, go to IDLE.
  - WbDataOut=DmemRdData for a load, ALUOutIn for a store.
  - WrNumOut=WrNumIn, RfWrEnableOut=RfWrEnableIn.
- StallOut is combinational: (IDLE & memop) | (WAIT & ~DmemAck).
  - Upstream holds inputs stable while StallOut=1.
  - EX/MEM advances on the ack edge, so back-to-back memops run IDLE→WAIT→IDLE→WAIT.
  - Minimum memop latency is 2 cycles (ack in the first WAIT cycle).
- DmemAck in IDLE is ignored.
- Reset asserted mid-WAIT: DmemReq drops immediately and the access is abandoned. The memory side tolerates a dropped request.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 without ack, the next edge returns to IDLE and drops DmemReq.
  - That edge writes WbDataOut=0, RfWrEnableOut=0 and pulses MemErrOut=1 for one cycle. StallOut releases in the abort cycle.
  - Ack in the same cycle as the limit wins: normal completion, no error.
- MEM_TIMEOUT_EN undefined: no counter, MemErrOut constant 0, WAIT holds indefinitely.

Decomposition:
- Shared Types.v gets: DATA_WIDTH, REG_NUM_WIDTH, DMEM_ADDR_WIDTH and the DmemAddrPath macro, plus state encodings MEM_ST_IDLE/MEM_ST_WAIT.
- One natural sub-module: mem_timeout_counter (clear, enable, limit-hit output), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Reset mid-WAIT (rst low with DmemReq=1) → DmemReq, StallOut and RfWrEnableOut all 0 immediately; after release, IDLE and non-memop passthrough works.
- Non-memop ALUOutIn=0x1234, WrNumIn=5, RfWrEnableIn=1 → next cycle WbDataOut=0x1234, WrNumOut=5, RfWrEnableOut=1, StallOut=0, DmemReq=0.
- Load at 0x40, DmemAck after 3 WAIT cycles with DmemRdData=0xDEADBEEF:
  - DmemAddr=0x10, DmemWe=0.
  - StallOut=1 for 4 cycles (IDLE cycle plus 3 WAIT cycles without ack); RfWrEnableOut=0 over that span.
  - Edge after ack: WbDataOut=0xDEADBEEF, RfWrEnableOut=1.
- Store at 0x7 with RdDataBIn=0xA5A5A5A5, ack in the first WAIT cycle → DmemAddr=0x1, DmemWe=1, DmemWrData=0xA5A5A5A5, total stall 1 cycle.
- Back-to-back load then store, each acked in the first WAIT cycle → two distinct requests, DmemReq low for exactly one cycle between them, correct addresses each time.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → after 4 WAIT cycles: one-cycle MemErrOut pulse, DmemReq=0, RfWrEnableOut=0, StallOut released.
